// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg: shared definitions for the memory-mapped UART.
//   - register byte offsets (bits [3:2] select the register)
//   - STATUS bit indices
//   - TX / RX engine state enums
package uart_mmio_pkg;

  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h4;
  localparam logic [3:0] REG_CTRL   = 4'h8;
  localparam logic [3:0] REG_DIV    = 4'hC;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_RX_VALID  = 1;
  localparam int ST_TX_FULL   = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_RX_OVR    = 4;
  localparam int ST_FRAME_ERR = 5;

  localparam int CTRL_RX_IRQ_EN = 0;
  localparam int CTRL_TX_IRQ_EN = 1;

  // Smallest divisor the engines can run with (mid-bit sampling needs >= 4 cycles/bit).
  localparam int DIV_MIN = 3;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and a combinational head.
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_push, i_data      write strobe / data
//   i_pop               read strobe (ignored when empty)
//   o_data              current head entry
//   o_full, o_empty     occupancy flags
// A push while full is accepted only if an effective pop happens in the same
// cycle; callers that must drop on full gate i_push themselves.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage is not reset; pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped UART with TX/RX FIFOs, programmable divisor,
// sticky error flags and a registered interrupt.
// Ports:
//   clk, reset_n_i                 clock, async active-low reset
//   sel_i, we_i, addr_i, data_in_i single-cycle bus access
//   data_out_o                     combinational read data
//   rx_i                           async serial input
//   tx_o                           serial output (idle high)
//   irq_o                          registered interrupt
// Map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC DIV. Bit period = DIV+1 cycles.
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter int FREQ_MHZ   = 12,
  parameter int BAUDS      = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        sel_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int               DIV_RST_I = FREQ_MHZ * 1_000_000 / BAUDS - 1;
  localparam logic [DIV_W-1:0] DIV_RST   = DIV_W'(DIV_RST_I);
  localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  // ---------------- bus decode ----------------
  logic w_is_data, w_is_status, w_is_ctrl, w_is_div, w_wr, w_rd;
  logic w_unused;

  assign w_is_data   = (addr_i[3:2] == REG_DATA[3:2]);
  assign w_is_status = (addr_i[3:2] == REG_STATUS[3:2]);
  assign w_is_ctrl   = (addr_i[3:2] == REG_CTRL[3:2]);
  assign w_is_div    = (addr_i[3:2] == REG_DIV[3:2]);
  assign w_wr        = sel_i & we_i;
  assign w_rd        = sel_i & ~we_i;
  assign w_unused    = ^{addr_i[1:0], data_in_i};

  // ---------------- registers ----------------
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_ctrl;
  logic             r_ovr, r_ferr, r_irq;
  logic [DIV_W-1:0] w_div_wdata;

  // ---------------- TX path signals ----------------
  tx_state_t        r_tx_state, w_tx_state_nxt;
  logic [DIV_W-1:0] r_tx_cnt, r_tx_div;
  logic [2:0]       r_tx_bit;
  logic [7:0]       r_tx_shift;
  logic             r_tx_o;
  logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_bit_end;
  logic [7:0]       w_tx_head;

  // ---------------- RX path signals ----------------
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic             r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DIV_W-1:0] r_rx_cnt, r_rx_div, w_rx_half;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic             w_rx_bit_end, w_rx_mid_hit, w_set_ferr, w_set_ovr;
  logic [7:0]       w_rx_head;

  // ---------------- FIFOs ----------------
  // TX writes to a full FIFO are dropped even if the engine pops that cycle.
  assign w_tx_push = w_wr & w_is_data & ~w_tx_full;
  assign w_rx_pop  = w_rd & w_is_data & ~w_rx_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n_i),
    .i_push  (w_tx_push),
    .i_data  (data_in_i[7:0]),
    .i_pop   (w_tx_pop),
    .o_data  (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  // RX push on a full FIFO succeeds when a DATA read pops in the same cycle.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (clk),
    .i_rst_n (reset_n_i),
    .i_push  (w_rx_push),
    .i_data  (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  assign w_set_ovr = w_rx_push & w_rx_full & ~w_rx_pop;

  // ---------------- register file ----------------
  assign w_div_wdata = data_in_i[DIV_W-1:0];

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_div  <= DIV_RST;
      r_ctrl <= '0;
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_is_ctrl) r_ctrl <= data_in_i[1:0];
      if (w_wr && w_is_div)  r_div  <= (w_div_wdata < DIV_FLOOR) ? DIV_FLOOR : w_div_wdata;
      // A new error event wins over a same-cycle clear so it is never lost.
      if (w_set_ovr)                                          r_ovr <= 1'b1;
      else if (w_wr && w_is_status && data_in_i[ST_RX_OVR])   r_ovr <= 1'b0;
      if (w_set_ferr)                                         r_ferr <= 1'b1;
      else if (w_wr && w_is_status && data_in_i[ST_FRAME_ERR]) r_ferr <= 1'b0;
      r_irq <= (r_ctrl[CTRL_RX_IRQ_EN] & ~w_rx_empty) |
               (r_ctrl[CTRL_TX_IRQ_EN] & w_tx_empty & (r_tx_state == TX_IDLE));
    end
  end

  always_comb begin
    data_out_o = '0;
    unique case (addr_i[3:2])
      REG_DATA[3:2]:   data_out_o = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
      REG_STATUS[3:2]: begin
        data_out_o[ST_TX_BUSY]   = ~w_tx_empty | (r_tx_state != TX_IDLE);
        data_out_o[ST_RX_VALID]  = ~w_rx_empty;
        data_out_o[ST_TX_FULL]   = w_tx_full;
        data_out_o[ST_RX_FULL]   = w_rx_full;
        data_out_o[ST_RX_OVR]    = r_ovr;
        data_out_o[ST_FRAME_ERR] = r_ferr;
      end
      REG_CTRL[3:2]:   data_out_o[1:0] = r_ctrl;
      default:         data_out_o = 32'(r_div);
    endcase
  end

  assign irq_o = r_irq;
  assign tx_o  = r_tx_o;

  // ---------------- TX engine ----------------
  assign w_tx_bit_end = (r_tx_cnt == r_tx_div);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) r_tx_state <= TX_IDLE;
    else            r_tx_state <= w_tx_state_nxt;
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_pop       = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (!w_tx_empty) begin
        w_tx_pop       = 1'b1;
        w_tx_state_nxt = TX_START;
      end
      TX_START: if (w_tx_bit_end) w_tx_state_nxt = TX_DATA;
      TX_DATA:  if (w_tx_bit_end && r_tx_bit == 3'd7) w_tx_state_nxt = TX_STOP;
      TX_STOP:  if (w_tx_bit_end) begin
        // Chain straight into the next start bit: no idle gap between frames.
        if (!w_tx_empty) begin
          w_tx_pop       = 1'b1;
          w_tx_state_nxt = TX_START;
        end else begin
          w_tx_state_nxt = TX_IDLE;
        end
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  // Datapath: DIV is latched per frame so mid-frame writes wait for the next start bit.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tx_o     <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_div   <= DIV_RST;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else if (w_tx_pop) begin
      r_tx_shift <= w_tx_head;
      r_tx_div   <= r_div;
      r_tx_cnt   <= '0;
      r_tx_o     <= 1'b0;
    end else if (r_tx_state != TX_IDLE) begin
      if (w_tx_bit_end) begin
        r_tx_cnt <= '0;
        case (r_tx_state)
          TX_START: begin
            r_tx_o   <= r_tx_shift[0];
            r_tx_bit <= '0;
          end
          TX_DATA: begin
            if (r_tx_bit == 3'd7) begin
              r_tx_o <= 1'b1;
            end else begin
              r_tx_o     <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_bit   <= r_tx_bit + 1'b1;
            end
          end
          default: r_tx_o <= 1'b1;
        endcase
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // ---------------- RX engine ----------------
  // Start-bit sample point: (DIV+1)/2 cycles after the edge, i.e. cnt == (DIV-1)/2.
  assign w_rx_half    = (r_rx_div - DIV_ONE) >> 1;
  assign w_rx_bit_end = (r_rx_cnt == r_rx_div);
  assign w_rx_mid_hit = (r_rx_cnt == w_rx_half);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_s1    <= rx_i;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_state_nxt;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_push      = 1'b0;
    w_set_ferr     = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = RX_START;
      RX_START: if (w_rx_mid_hit) w_rx_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_rx_bit_end && r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
      RX_STOP:  if (w_rx_bit_end) begin
        if (r_rx_s2) begin
          w_rx_push      = 1'b1;
          w_rx_state_nxt = RX_IDLE;
        end else begin
          w_set_ferr     = 1'b1;
          w_rx_state_nxt = RX_WAIT_HIGH;
        end
      end
      RX_WAIT_HIGH: if (r_rx_s2) w_rx_state_nxt = RX_IDLE;
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_cnt   <= '0;
      r_rx_div   <= DIV_RST;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          r_rx_bit <= '0;
          if (w_rx_state_nxt == RX_START) r_rx_div <= r_div;
        end
        RX_START: r_rx_cnt <= w_rx_mid_hit ? '0 : r_rx_cnt + 1'b1;
        RX_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: r_rx_cnt <= r_rx_cnt + 1'b1;
        default: r_rx_cnt <= '0;
      endcase
    end
  end

endmodule

// File: doc/uart_mmio.md
# uart_mmio

Memory-mapped UART peripheral: the successor to the single-byte UART slot in the SoC address map. It has parametrised-depth TX and RX FIFOs, a run-time programmable baud divisor, sticky error flags and an interrupt output. It sits on the processor's single-cycle bus behind the SoC address decoder, which asserts `sel_i` for the UART region. It drives the `tx_o` and `rx_i` pins directly; no separate UART core is needed.

## Interface
- `FREQ_MHZ`, 12: system clock in MHz.
- `BAUDS`, 115200: reset baud rate. DIV resets to FREQ_MHZ*1_000_000/BAUDS − 1.
- `FIFO_DEPTH`, 16: entries per FIFO. Power of two, ≥2.
- `DIV_W`, 16: divisor register width.
- `clk` in 1: single clock.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `sel_i` in 1: access strobe, one cycle per access.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in 4: byte offset; bits [3:2] select the register.
- `data_in_i` in 32: write data.
- `data_out_o` out 32: read data, combinational from `addr_i` and current state.
- `rx_i` in 1: serial input, asynchronous to `clk`.
- `tx_o` out 1: serial output, idle high.
- `irq_o` out 1: registered interrupt.

## Operation
Registers (unlisted bits read 0, writes ignored):
- 0x0 DATA.
  - Write: push `data_in_i[7:0]` to TX FIFO. If the FIFO is full, the write is silently dropped.
  - Read: returns {24'd0, RX head}, and the `sel_i` read cycle pops the entry. If the FIFO is empty, returns 0 and pops nothing.
- 0x4 STATUS.
  - Bits: 0 tx_busy (TX FIFO non-empty or shifter active), 1 rx_valid, 2 tx_full, 3 rx_full, 4 rx_overrun (sticky), 5 frame_err (sticky).
  - Writing 1 to bit 4 or bit 5 clears that bit. All other bits are read-only.
- 0x8 CTRL: bit 0 rx_irq_en, bit 1 tx_irq_en. Reset 0.
- 0xC DIV: bit period is DIV+1 cycles. Written values below 3 are stored as 3.

TX engine, states IDLE → START → DATA → STOP → IDLE:
- In IDLE with the FIFO non-empty: pop the head and latch DIV, then go to START.
- Frame: start bit 0, 8 data bits LSB first, 1 stop bit.
- After STOP: go directly to START if the FIFO is non-empty, otherwise to IDLE. There is no idle gap between back-to-back frames.

RX engine, states IDLE → START → DATA → STOP → (WAIT_HIGH) → IDLE:
- `rx_i` passes through a 2-flop synchroniser. A falling edge in IDLE latches DIV and enters START.
- START: sample at (DIV+1)/2 cycles. If the line is high, this is a false start; return to IDLE.
- DATA: sample each bit every DIV+1 cycles thereafter.
- Stop bit = 1: push the byte. If the FIFO is full, drop the byte and set rx_overrun.
- Stop bit = 0: set frame_err, discard the byte, go to WAIT_HIGH. Leave WAIT_HIGH for IDLE when the synchronised line is high.

Interrupt and boundary rules:
- `irq_o` = (rx_irq_en & rx_valid) | (tx_irq_en & TX FIFO empty & !shifter active), registered.
- RX push and DATA-read pop in the same cycle on a full FIFO: both succeed, no overrun.
- TX push and engine pop in the same cycle: both succeed. A push to a full FIFO is dropped even if a pop occurs that cycle.
- A DIV write mid-frame does not affect the current frame; it applies from the next start bit.
- Reset mid-frame: `tx_o` goes to 1 immediately and the partial RX byte is lost.

## Timing
- Reset values:
  - `tx_o` = 1, `irq_o` = 0.
  - Both FIFOs empty, all flags 0, CTRL = 0, DIV = reset divisor.
  - `data_out_o` for STATUS = 0.
- TX latency: a DATA write at edge N into an idle engine drives the start bit on `tx_o` from edge N+1. Each bit lasts exactly DIV+1 cycles.
- RX latency: rx_valid asserts ≤ 3 cycles after the mid-point of the stop bit.
- `irq_o` lags its inputs by 1 cycle.

## Structure
- `uart_mmio_pkg` contains:
  - register offsets (REG_DATA, REG_STATUS, REG_CTRL, REG_DIV);
  - STATUS bit indices;
  - `tx_state_t` and `rx_state_t` enums.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH; outputs full/empty; simultaneous push/pop supported) is instantiated twice.

## Test plan
Configuration: FREQ_MHZ=12, BAUDS=1_000_000, FIFO_DEPTH=16, giving DIV reset 11 (12 cycles/bit).
- Reset: release `reset_n_i` → STATUS reads 0x0, DIV reads 11, `tx_o`=1, `irq_o`=0.
- TX frame: write 0x55 to DATA → `tx_o`=0 at the next cycle, then 1,0,1,0,1,0,1,0 and stop bit 1, each held 12 cycles. tx_busy clears 120 cycles after the write.
- Loopback (`tx_o`→`rx_i`): write 0xA5 then 0x3C → both frames are back-to-back. Reads return 0xA5 then 0x3C; rx_valid then = 0.
- Overflow: receive 17 bytes 0x00..0x10 without reading → STATUS = 0x1A (rx_valid, rx_full, rx_overrun). Reads return 0x00..0x0F. Writing 0x10 to STATUS clears rx_overrun.
- Errors: drive a frame with stop bit 0 → frame_err=1 and RX FIFO stays empty. Drive a 4-cycle low glitch → no state change.
- DIV and IRQ: write DIV=23 during a TX frame → that frame stays at 12 cycles/bit, the next at 24. With CTRL=0x2 and the TX FIFO drained, `irq_o`=1 one cycle after the shifter goes idle.
